// File: rtl/irq_priority_ctrl8_pkg.sv
// Shared definitions for the 8-line priority interrupt controller:
// FSM state encoding and vector sizes.
package irq_priority_ctrl8_pkg;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/priority_encoder8to3.sv
// Returns the index of the highest set bit of an 8-bit vector.
// The output is meaningless when the input is all zeros.
module priority_encoder8to3 (
  input  logic [7:0] in_vec,
  output logic [2:0] out_id
);

  always_comb begin
    out_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (in_vec[i]) out_id = i[2:0];
    end
  end

endmodule

// File: rtl/irq_priority_ctrl8.sv
// Eight-line interrupt controller: edge or level capture into a pending
// vector, maskable fixed-priority selection, one request presented at a time.
import irq_priority_ctrl8_pkg::*;

module irq_priority_ctrl8 #(
  parameter int EDGE_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_wdata,
  input  logic                irq_ack,
  output logic                irq_valid,
  output logic [ID_W-1:0]     irq_id,
  output logic [NUM_IRQ-1:0]  pending
);

  logic [NUM_IRQ-1:0] irq_prev_reg;
  logic [NUM_IRQ-1:0] mask_reg;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] edge_vec;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] eligible;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    id_reg;
  logic               valid_reg;
  state_t             state_reg;

  assign edge_vec = irq_in & ~irq_prev_reg;
  assign set_vec  = (EDGE_MODE != 0) ? edge_vec : irq_in;
  assign eligible = pending_reg & ~mask_reg;

  always_comb begin
    clr_vec = '0;
    if (state_reg == PRESENT && irq_ack) clr_vec[id_reg] = 1'b1;
  end

  // A new capture in the same cycle as the ack-clear keeps the bit pending.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
      assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
    end
  endgenerate

  priority_encoder8to3 u_enc (
    .in_vec (eligible),
    .out_id (sel_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev_reg <= '0;
      mask_reg     <= '0;
      pending_reg  <= '0;
    end else begin
      irq_prev_reg <= irq_in;
      pending_reg  <= pending_next;
      if (mask_we) mask_reg <= mask_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      id_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (eligible != '0) begin
            state_reg <= PRESENT;
            valid_reg <= 1'b1;
            id_reg    <= sel_id;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign irq_valid = valid_reg;
  assign irq_id    = id_reg;
  assign pending   = pending_reg;

endmodule

// File: tb/tb_irq_priority_ctrl8.sv
// Directed bench: one edge-mode and one level-mode controller, inputs driven
// and outputs sampled on the falling clock edge.
module tb_irq_priority_ctrl8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_in = 8'h00, mask_wdata = 8'h00;
  logic       mask_we = 1'b0, irq_ack = 1'b0;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] irq_in_l = 8'h00;
  logic       irq_ack_l = 1'b0;
  logic       irq_valid_l;
  logic [2:0] irq_id_l;
  logic [7:0] pending_l;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  irq_priority_ctrl8 #(.EDGE_MODE(1)) u_edge (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .irq_ack(irq_ack),
    .irq_valid(irq_valid), .irq_id(irq_id), .pending(pending)
  );

  irq_priority_ctrl8 #(.EDGE_MODE(0)) u_lvl (
    .clk(clk), .rst(rst), .irq_in(irq_in_l), .mask_we(1'b0),
    .mask_wdata(8'h00), .irq_ack(irq_ack_l),
    .irq_valid(irq_valid_l), .irq_id(irq_id_l), .pending(pending_l)
  );

  // Edge-mode outputs against expected valid/id/pending in one go.
  `define CHK_E(NAME, V, ID, P) \
    total++; \
    if (irq_valid !== (V) || ((V) && irq_id !== (ID)) || pending !== (P)) begin \
      bad++; \
      $display("FAIL %s: valid=%0b id=%0d pending=%02h, expected valid=%0b id=%0d pending=%02h", \
               NAME, irq_valid, irq_id, pending, (V), (ID), (P)); \
    end else $display("ok   %s: valid=%0b id=%0d pending=%02h", NAME, irq_valid, irq_id, pending);

  `define CHK_L(NAME, V, ID, P) \
    total++; \
    if (irq_valid_l !== (V) || ((V) && irq_id_l !== (ID)) || pending_l !== (P)) begin \
      bad++; \
      $display("FAIL %s: valid=%0b id=%0d pending=%02h, expected valid=%0b id=%0d pending=%02h", \
               NAME, irq_valid_l, irq_id_l, pending_l, (V), (ID), (P)); \
    end else $display("ok   %s: valid=%0b id=%0d pending=%02h", NAME, irq_valid_l, irq_id_l, pending_l);

  task automatic test_reset();
    irq_in = 8'hFF;
    irq_in_l = 8'hFF;
    repeat (3) @(negedge clk);
    total++;
    if (irq_valid !== 1'b0 || irq_id !== 3'd0 || pending !== 8'h00) begin
      bad++;
      $display("FAIL reset_edge: valid=%0b id=%0d pending=%02h, expected 0/0/00", irq_valid, irq_id, pending);
    end else $display("ok   reset_edge");
    total++;
    if (irq_valid_l !== 1'b0 || irq_id_l !== 3'd0 || pending_l !== 8'h00) begin
      bad++;
      $display("FAIL reset_lvl: valid=%0b id=%0d pending=%02h, expected 0/0/00", irq_valid_l, irq_id_l, pending_l);
    end else $display("ok   reset_lvl");
    irq_in = 8'h00;
    irq_in_l = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    `CHK_E("post_reset_idle", 1'b0, 3'd0, 8'h00)
  endtask

  task automatic test_single_edge();
    irq_in = 8'h04;
    @(negedge clk);
    `CHK_E("single_pend", 1'b0, 3'd0, 8'h04)
    @(negedge clk);
    `CHK_E("single_present", 1'b1, 3'd2, 8'h04)
    irq_ack = 1'b1;
    @(negedge clk);
    `CHK_E("single_acked", 1'b0, 3'd0, 8'h00)
    irq_ack = 1'b0;
    irq_in = 8'h00;
    @(negedge clk);
    `CHK_E("single_ack_idle_ignored", 1'b0, 3'd0, 8'h00)
  endtask

  task automatic test_priority();
    irq_in = 8'h81;
    @(negedge clk);
    `CHK_E("prio_pend", 1'b0, 3'd0, 8'h81)
    @(negedge clk);
    `CHK_E("prio_first", 1'b1, 3'd7, 8'h81)
    irq_ack = 1'b1;
    @(negedge clk);
    `CHK_E("prio_gap", 1'b0, 3'd0, 8'h01)
    irq_ack = 1'b0;
    @(negedge clk);
    `CHK_E("prio_second", 1'b1, 3'd0, 8'h01)
    irq_ack = 1'b1;
    @(negedge clk);
    `CHK_E("prio_done", 1'b0, 3'd0, 8'h00)
    irq_ack = 1'b0;
    irq_in = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_mask_stability();
    irq_in = 8'h08;
    repeat (2) @(negedge clk);
    `CHK_E("stab_present3", 1'b1, 3'd3, 8'h08)
    irq_in = 8'h48;
    mask_we = 1'b1;
    mask_wdata = 8'h08;
    @(negedge clk);
    `CHK_E("stab_hold3_a", 1'b1, 3'd3, 8'h48)
    mask_we = 1'b0;
    @(negedge clk);
    `CHK_E("stab_hold3_b", 1'b1, 3'd3, 8'h48)
    irq_ack = 1'b1;
    @(negedge clk);
    `CHK_E("stab_ack3", 1'b0, 3'd0, 8'h40)
    irq_ack = 1'b0;
    @(negedge clk);
    `CHK_E("stab_present6", 1'b1, 3'd6, 8'h40)
    irq_ack = 1'b1;
    @(negedge clk);
    `CHK_E("stab_done", 1'b0, 3'd0, 8'h00)
    irq_ack = 1'b0;
    irq_in = 8'h00;
    mask_we = 1'b1;
    mask_wdata = 8'h00;
    @(negedge clk);
    mask_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_masked_pending();
    mask_we = 1'b1;
    mask_wdata = 8'h02;
    @(negedge clk);
    mask_we = 1'b0;
    irq_in = 8'h02;
    repeat (3) @(negedge clk);
    `CHK_E("masked_held", 1'b0, 3'd0, 8'h02)
    mask_we = 1'b1;
    mask_wdata = 8'h00;
    @(negedge clk);
    mask_we = 1'b0;
    @(negedge clk);
    `CHK_E("unmasked_present", 1'b1, 3'd1, 8'h02)
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    irq_in = 8'h00;
    @(negedge clk);
    `CHK_E("unmasked_done", 1'b0, 3'd0, 8'h00)
  endtask

  task automatic test_collision();
    irq_in = 8'h20;
    repeat (2) @(negedge clk);
    `CHK_E("coll_present5", 1'b1, 3'd5, 8'h20)
    irq_in = 8'h00;
    @(negedge clk);
    irq_in = 8'h20;
    irq_ack = 1'b1;
    @(negedge clk);
    `CHK_E("coll_set_wins", 1'b0, 3'd0, 8'h20)
    irq_ack = 1'b0;
    @(negedge clk);
    `CHK_E("coll_represent5", 1'b1, 3'd5, 8'h20)
    irq_ack = 1'b1;
    @(negedge clk);
    `CHK_E("coll_done", 1'b0, 3'd0, 8'h00)
    irq_ack = 1'b0;
    irq_in = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_level_reset();
    irq_in_l = 8'h02;
    @(negedge clk);
    `CHK_L("lvl_pend", 1'b0, 3'd0, 8'h02)
    @(negedge clk);
    `CHK_L("lvl_present1", 1'b1, 3'd1, 8'h02)
    #2 rst = 1'b1;
    #1;
    `CHK_L("lvl_async_reset", 1'b0, 3'd0, 8'h00)
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    `CHK_L("lvl_repend", 1'b0, 3'd0, 8'h02)
    @(negedge clk);
    `CHK_L("lvl_represent1", 1'b1, 3'd1, 8'h02)
    irq_ack_l = 1'b1;
    @(negedge clk);
    `CHK_L("lvl_ack_still_high", 1'b0, 3'd0, 8'h02)
    irq_ack_l = 1'b0;
    @(negedge clk);
    `CHK_L("lvl_again1", 1'b1, 3'd1, 8'h02)
    irq_in_l = 8'h00;
    irq_ack_l = 1'b1;
    @(negedge clk);
    `CHK_L("lvl_done", 1'b0, 3'd0, 8'h00)
    irq_ack_l = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_priority();
    test_mask_stability();
    test_masked_pending();
    test_collision();
    test_level_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_priority_ctrl8.md
IRQ_PRIORITY_CTRL8 -- requirements
Module: irq_priority_ctrl8

Interface
REQ-001 Parameter EDGE_MODE, default 1: 1 = rising-edge capture of irq_in; 0 = level capture.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 irq_in  input  8  raw request lines; bit 7 highest priority, bit 0 lowest.
REQ-005 mask_we  input  1  mask write strobe, sampled on clk.
REQ-006 mask_wdata  input  8  new mask value; 1 = bit masked.
REQ-007 irq_ack  input  1  consumer acknowledge of the presented request.
REQ-008 irq_valid  output  1  a request is being presented.
REQ-009 irq_id  output  3  index of the presented request.
REQ-010 pending  output  8  registered pending vector, unmasked view.

Function
REQ-011 The edge detector SHALL register irq_in into irq_prev each cycle; an edge event is irq_in & ~irq_prev.
REQ-012 With EDGE_MODE=1, pending[i] SHALL set on the cycle after an edge event on bit i.
REQ-013 With EDGE_MODE=0, pending[i] SHALL set on the cycle after irq_in[i] is sampled high.
REQ-014 The mask register SHALL load mask_wdata on the cycle after mask_we=1; masking SHALL gate only selection, never pending.
REQ-015 Eligible vector = pending & ~mask; the selected id SHALL be the index of its highest set bit.
REQ-016 FSM states: IDLE, PRESENT.
REQ-017 IDLE -> PRESENT when the eligible vector is nonzero; irq_id SHALL be latched with the selected id on that transition.
REQ-018 In PRESENT, irq_valid SHALL be 1, and irq_id SHALL hold stable until it is acknowledged, regardless of new requests or mask writes.
REQ-019 PRESENT with irq_ack=1 SHALL clear pending[irq_id] and return to IDLE; irq_valid SHALL be 0 the following cycle.
REQ-020 irq_ack in IDLE SHALL be ignored.
REQ-021 Latency: an edge sampled at cycle N sets pending at N+1; irq_valid rises at N+2 when the request is eligible and the FSM is in IDLE.
REQ-022 A set event and the ack-clear on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-023 Back-to-back operation: after an ack, the next eligible request SHALL present no earlier than 1 cycle after irq_valid falls; there SHALL be at least 1 IDLE cycle between presentations.
REQ-024 In level mode, a line still high after its ack SHALL re-pend and re-present.
REQ-025 Masking a bit while it is pending SHALL hold it pending; unmasking SHALL make it eligible on the next IDLE evaluation.

Reset
REQ-026 Reset SHALL force the following, immediately and regardless of clk: pending=0, mask=8'h00, irq_prev=0, state=IDLE, irq_valid=0, irq_id=0.
REQ-027 Reset asserted mid-PRESENT SHALL drop irq_valid without an ack; the request SHALL be lost.
REQ-028 Because irq_prev resets to 0, a line already high at reset release SHALL register one edge event.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding (IDLE=0, PRESENT=1) and the constants NUM_IRQ=8 and ID_W=3.
REQ-030 The block SHALL instantiate the existing priority_encoder8to3 on the eligible vector as its sole sub-module; its output is don't-care when the input is zero.
REQ-031 Implementation SHALL be 120-400 lines of RTL with no latches and all outputs registered.

Verification
REQ-032 Reset: rst=1 with irq_in=8'hFF -> irq_valid=0, irq_id=0, pending=0 while rst is held.
REQ-033 Single edge: irq_in 0->8'h04 at cycle N -> pending=8'h04 at N+1, irq_valid=1 with irq_id=2 at N+2; ack -> pending=0, irq_valid=0.
REQ-034 Priority: edges on 8'h81 in the same cycle -> id 7 presented first; after ack, id 0 presented following one IDLE cycle.
REQ-035 Stability and masking: id 3 presented, then an edge on bit 6 plus mask_wdata=8'h08 -> irq_id stays 3 until ack; bit 6 then presents.
REQ-036 Set/clear collision (EDGE_MODE=1): new edge on bit 5 in the ack cycle of id 5 -> pending[5] stays 1 and id 5 re-presents.
REQ-037 Mid-operation reset, level mode: rst pulses during PRESENT with id 1 -> irq_valid=0 at once; after release with irq_in[1] still high, id 1 presents again.
